// File: rtl/eq_const_pkg.sv
// Shared elaboration-time helpers for the constant-compare pipeline:
// chunk count, reduction-tree geometry, latency and LUT truth tables.
package eq_const_pkg;

  localparam int CHUNK_W   = 6;  // din bits examined by one level-0 LUT
  localparam int LUT_FANIN = 6;  // inputs of one AND-reduction LUT

  // Number of 6-bit chunks for a word of the given width.
  function automatic int chunk_count(input int width);
    return (width + CHUNK_W - 1) / CHUNK_W;
  endfunction

  // Number of bits left after lvl rounds of 6:1 reduction.
  function automatic int level_width(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + LUT_FANIN - 1) / LUT_FANIN;
    return c;
  endfunction

  // Registered reduction levels needed to get n bits down to one (ceil log6).
  function automatic int tree_levels(input int n);
    int c;
    int l;
    c = n;
    l = 0;
    while (c > 1) begin
      c = (c + LUT_FANIN - 1) / LUT_FANIN;
      l++;
    end
    return l;
  endfunction

  // Cycles from din sampled to match presented.
  function automatic int pipe_latency(input int width);
    return 1 + tree_levels(chunk_count(width));
  endfunction

  // Bit offset of level lvl inside the flattened tree vector.
  function automatic int level_offset(input int n, input int lvl);
    int s;
    s = 0;
    for (int i = 0; i < lvl; i++) s += level_width(n, i);
    return s;
  endfunction

  // Truth table of a 6-input LUT that is 1 for every input agreeing with
  // val on the care bits.
  function automatic logic [63:0] lut_mask(input logic [5:0] val, input logic [5:0] care);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 64; k++) begin
      if (((6'(k) ^ val) & care) == 6'd0) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/eq_const_pipe_if.sv
// Bundle of the compare pipeline's data-side signals.
// Handshake: din_valid qualifies din in the cycle it is high; there is no
// backpressure, so every valid cycle is a accepted word. match_valid marks
// the cycle in which match carries the result for one such word.
interface eq_const_pipe_if #(
  parameter int WIDTH     = 48,
  parameter int CNT_WIDTH = 16
) (
  input logic clk
);

  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 clear_stats;
  logic                 match;
  logic                 match_valid;
  logic [CNT_WIDTH-1:0] match_cnt;
  logic                 sticky_match;

  modport master (
    input  clk,
    output din, din_valid, clear_stats,
    input  match, match_valid, match_cnt, sticky_match
  );

  modport slave (
    input  clk,
    input  din, din_valid, clear_stats,
    output match, match_valid, match_cnt, sticky_match
  );

endinterface

// File: rtl/eq_chunk_reg.sv
// One 6-bit masked constant compare mapped to a single LUT, registered.
// The register has no reset: its output is only observed when qualified
// by the valid pipeline.
module eq_chunk_reg
  import eq_const_pkg::*;
#(
  parameter int         TARGET_CHIP = 2,
  parameter logic [5:0] VAL6        = 6'd0,
  parameter logic [5:0] CARE6       = 6'h3F
) (
  input  logic       clk,
  input  logic [5:0] i_d,
  output logic       o_q
);

  localparam logic [63:0] LUT_MASK = lut_mask(VAL6, CARE6);

  if (TARGET_CHIP < 0) begin : g_bad_chip
    $error("eq_chunk_reg: TARGET_CHIP must be non-negative");
  end

  logic w_hit;
  logic r_q;

  assign w_hit = LUT_MASK[i_d];

  // Level-0 pipeline register for this chunk's compare result.
  always_ff @(posedge clk) begin
    r_q <= w_hit;
  end

  assign o_q = r_q;

endmodule

// File: rtl/eq_const_pipe.sv
// Pipelined compare of din against a masked constant: 6-bit chunk LUTs,
// then a registered 6:1 AND tree, plus a saturating match counter and a
// sticky match flag. Accepts one word per cycle, never stalls.
module eq_const_pipe
  import eq_const_pkg::*;
#(
  parameter int               TARGET_CHIP = 2,
  parameter int               WIDTH       = 48,
  parameter logic [WIDTH-1:0] VAL         = WIDTH'(48'h0123_4567_89AB),
  parameter logic [WIDTH-1:0] CARE        = '1,
  parameter int               CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 clear_stats,
  output logic                 match,
  output logic                 match_valid,
  output logic [CNT_WIDTH-1:0] match_cnt,
  output logic                 sticky_match
);

  localparam int NCH       = chunk_count(WIDTH);
  localparam int LEVELS    = tree_levels(NCH);
  localparam int LATENCY   = pipe_latency(WIDTH);
  localparam int PADW      = NCH * CHUNK_W;
  localparam int TREE_BITS = level_offset(NCH, LEVELS + 1);

  // Bits above WIDTH get CARE=0 so the padded top chunk ignores them.
  localparam logic [PADW-1:0]      VAL_PAD  = PADW'(VAL);
  localparam logic [PADW-1:0]      CARE_PAD = PADW'(CARE);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("eq_const_pipe: WIDTH must be in 1..256");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt
    $error("eq_const_pipe: CNT_WIDTH must be in 1..32");
  end

  logic [PADW-1:0]      w_din_pad;
  logic [TREE_BITS-1:0] w_tree;     // all tree levels, level 0 at bit 0
  logic [LATENCY-1:0]   r_vld;
  logic                 w_match;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_sticky;

  // Zero-extend din to a whole number of chunks.
  always_comb begin
    w_din_pad              = '0;
    w_din_pad[WIDTH-1:0]   = din;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chunk
    eq_chunk_reg #(
      .TARGET_CHIP (TARGET_CHIP),
      .VAL6        (VAL_PAD[c*CHUNK_W +: CHUNK_W]),
      .CARE6       (CARE_PAD[c*CHUNK_W +: CHUNK_W])
    ) u_chunk (
      .clk (clk),
      .i_d (w_din_pad[c*CHUNK_W +: CHUNK_W]),
      .o_q (w_tree[c])
    );
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int N_IN    = level_width(NCH, l - 1);
    localparam int N_OUT   = level_width(NCH, l);
    localparam int OFF_IN  = level_offset(NCH, l - 1);
    localparam int OFF_OUT = level_offset(NCH, l);

    logic [N_OUT*LUT_FANIN-1:0] w_pad;
    logic [N_OUT-1:0]           w_and;
    logic [N_OUT-1:0]           r_and;

    // Fill a partial last group with ones so it ANDs as identity.
    always_comb begin
      w_pad           = '1;
      w_pad[N_IN-1:0] = w_tree[OFF_IN +: N_IN];
    end

    // One 6-input AND per group of previous-level results.
    always_comb begin
      w_and = '0;
      for (int g = 0; g < N_OUT; g++) begin
        w_and[g] = &w_pad[g*LUT_FANIN +: LUT_FANIN];
      end
    end

    // Register this tree level.
    always_ff @(posedge clk) begin
      r_and <= w_and;
    end

    assign w_tree[OFF_OUT +: N_OUT] = r_and;
  end

  // Valid shift register tracking each word through the pipeline; reset
  // drops every in-flight word.
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= din_valid;
      for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  assign w_match     = r_vld[LATENCY-1] & w_tree[TREE_BITS-1];
  assign match       = w_match;
  assign match_valid = r_vld[LATENCY-1];

  // Match statistics: reset wins, then clear (which still counts a
  // coincident match), then saturating increment.
  always_ff @(posedge clk) begin
    if (sclr) begin
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (clear_stats) begin
      r_cnt    <= w_match ? CNT_WIDTH'(1) : '0;
      r_sticky <= w_match;
    end else if (w_match) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_WIDTH'(1);
      r_sticky <= 1'b1;
    end
  end

  assign match_cnt    = r_cnt;
  assign sticky_match = r_sticky;

endmodule

// File: tb/tb_eq_const_pipe.sv
// Self-checking bench for eq_const_pipe: directed vector table on the
// default 48-bit instance and masked variants, hand sequences for
// back-to-back, saturation, clear and reset corners, and a width sweep
// against a reference compare with hand-derived latencies.
module tb_eq_const_pipe;

  localparam logic [47:0]  VAL48  = 48'h0123_4567_89AB;
  localparam logic [47:0]  CARE_M = 48'hFFFF_FFFF_FF00;
  localparam int           SW_N   = 6;
  localparam int           SW_CYC = 140;
  localparam int           SW_W   [SW_N] = '{1, 6, 7, 36, 37, 256};
  localparam int           SW_LAT [SW_N] = '{1, 1, 2, 2, 3, 4};
  localparam logic [255:0] SW_VAL  = {64'hDEAD_BEEF_0BAD_F00D, 64'h0123_4567_89AB_CDEF,
                                      64'hFEDC_BA98_7654_3210, 64'hC001_D00D_5EED_1235};
  localparam logic [255:0] SW_CARE = {8{32'hFFFF_FF7F}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic sclr;

  int checks = 0;
  int errors = 0;

  // ---------------- DUTs ----------------
  eq_const_pipe_if #(.WIDTH(48), .CNT_WIDTH(16)) bus (.clk(clk));

  eq_const_pipe u_main (
    .clk(clk), .sclr(sclr), .din(bus.din), .din_valid(bus.din_valid),
    .clear_stats(bus.clear_stats), .match(bus.match), .match_valid(bus.match_valid),
    .match_cnt(bus.match_cnt), .sticky_match(bus.sticky_match)
  );

  logic        mm_m, mm_v, mm_st;
  logic [15:0] mm_cnt;
  eq_const_pipe #(.CARE(CARE_M)) u_mask (
    .clk(clk), .sclr(sclr), .din(bus.din), .din_valid(bus.din_valid),
    .clear_stats(bus.clear_stats), .match(mm_m), .match_valid(mm_v),
    .match_cnt(mm_cnt), .sticky_match(mm_st)
  );

  logic        any_m, any_v, any_st;
  logic [15:0] any_cnt;
  eq_const_pipe #(.CARE(48'h0)) u_any (
    .clk(clk), .sclr(sclr), .din(bus.din), .din_valid(bus.din_valid),
    .clear_stats(bus.clear_stats), .match(any_m), .match_valid(any_v),
    .match_cnt(any_cnt), .sticky_match(any_st)
  );

  logic       c2_dv, c2_clr, c2_m, c2_mv, c2_st;
  logic [1:0] c2_cnt;
  eq_const_pipe #(.CNT_WIDTH(2)) u_c2 (
    .clk(clk), .sclr(sclr), .din(bus.din), .din_valid(c2_dv),
    .clear_stats(c2_clr), .match(c2_m), .match_valid(c2_mv),
    .match_cnt(c2_cnt), .sticky_match(c2_st)
  );

  logic [255:0]    sw_din [SW_N];
  logic [SW_N-1:0] sw_dv, sw_m, sw_mv, sw_st;
  logic [15:0]     sw_cnt [SW_N];

  for (genvar g = 0; g < SW_N; g++) begin : g_sw
    eq_const_pipe #(
      .WIDTH(SW_W[g]), .VAL(SW_VAL[SW_W[g]-1:0]), .CARE(SW_CARE[SW_W[g]-1:0]), .CNT_WIDTH(16)
    ) u_dut (
      .clk(clk), .sclr(sclr), .din(sw_din[g][SW_W[g]-1:0]), .din_valid(sw_dv[g]),
      .clear_stats(1'b0), .match(sw_m[g]), .match_valid(sw_mv[g]),
      .match_cnt(sw_cnt[g]), .sticky_match(sw_st[g])
    );
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] wmask(input int w);
    logic [255:0] m;
    m = '0;
    for (int b = 0; b < w; b++) m[b] = 1'b1;
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    tick();
    bus.clear_stats = 1'b1;
    tick();
    bus.clear_stats = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [47:0] din;
    logic        exp_m;    // default instance
    logic        exp_mm;   // low byte don't-care instance
    logic [15:0] exp_cnt;  // default instance count after this word
  } vec_t;

  vec_t       vecs [10];
  logic [47:0] b2b   [4];
  logic       exp_q [$];
  logic       em_bit;
  logic [255:0] rnd, d;
  logic       hv [SW_N][SW_CYC];
  logic       hm [SW_N][SW_CYC];
  int         nmatch [SW_N];
  logic       ev, em, dv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{VAL48,                    1'b1, 1'b1, 16'd1};
    vecs[1] = '{VAL48 ^ 48'd1,            1'b0, 1'b1, 16'd1};
    vecs[2] = '{VAL48 ^ (48'd1 << 47),    1'b0, 1'b0, 16'd1};
    vecs[3] = '{48'h0,                    1'b0, 1'b0, 16'd1};
    vecs[4] = '{VAL48 ^ (48'd1 << 24),    1'b0, 1'b0, 16'd1};
    vecs[5] = '{VAL48,                    1'b1, 1'b1, 16'd2};
    vecs[6] = '{48'h0123_4567_8900,       1'b0, 1'b1, 16'd2};
    vecs[7] = '{48'h0123_4567_8800,       1'b0, 1'b0, 16'd2};
    vecs[8] = '{48'h0123_4567_89FF,       1'b0, 1'b1, 16'd2};
    vecs[9] = '{VAL48,                    1'b1, 1'b1, 16'd3};
    b2b[0] = VAL48;
    b2b[1] = VAL48 ^ 48'd1;
    b2b[2] = VAL48 ^ (48'd1 << 47);
    b2b[3] = VAL48;

    sclr            = 1'b1;
    bus.din         = '0;
    bus.din_valid   = 1'b0;
    bus.clear_stats = 1'b0;
    c2_dv           = 1'b0;
    c2_clr          = 1'b0;
    for (int g = 0; g < SW_N; g++) begin
      sw_din[g] = '0;
      nmatch[g] = 0;
    end
    sw_dv = '0;

    // Reset state, sampled while sclr is still high.
    repeat (3) tick();
    chk("rst_mv", bus.match_valid, 0);
    chk("rst_match", bus.match, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    chk("rst_sticky", bus.sticky_match, 0);
    chk("rst_c2_cnt", c2_cnt, 0);
    sclr = 1'b0;
    repeat (2) tick();

    // Single words, each run to completion: latency, result, stats.
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.din       = vecs[i].din;
      bus.din_valid = 1'b1;
      tick();
      bus.din_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_mv_early", i), bus.match_valid, 0);
      tick();
      chk($sformatf("vec%0d_mv", i), bus.match_valid, 1);
      chk($sformatf("vec%0d_match", i), bus.match, vecs[i].exp_m);
      chk($sformatf("vec%0d_mask_mv", i), mm_v, 1);
      chk($sformatf("vec%0d_mask_match", i), mm_m, vecs[i].exp_mm);
      chk($sformatf("vec%0d_any_mv", i), any_v, 1);
      chk($sformatf("vec%0d_any_match", i), any_m, 1);
      tick();
      chk($sformatf("vec%0d_mv_after", i), bus.match_valid, 0);
      chk($sformatf("vec%0d_match_forced0", i), bus.match, 0);
      chk($sformatf("vec%0d_cnt", i), bus.match_cnt, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_sticky", i), bus.sticky_match, 1);
      chk($sformatf("vec%0d_any_cnt", i), any_cnt, 16'(i + 1));
    end
    chk("mask_cnt_total", mm_cnt, 6);
    chk("mask_sticky", mm_st, 1);
    chk("any_sticky", any_st, 1);

    // clear_stats alone.
    pulse_clear();
    chk("clr_cnt", bus.match_cnt, 0);
    chk("clr_sticky", bus.sticky_match, 0);

    // Back-to-back words, results on consecutive cycles.
    exp_q = {1'b1, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 7; t++) begin
      tick();
      if (t >= 3) begin
        em_bit = exp_q.pop_front();
        chk($sformatf("b2b_mv_t%0d", t), bus.match_valid, 1);
        chk($sformatf("b2b_match_t%0d", t), bus.match, em_bit);
      end else begin
        chk($sformatf("b2b_mv_t%0d", t), bus.match_valid, 0);
      end
      if (t < 4) begin
        bus.din       = b2b[t];
        bus.din_valid = 1'b1;
      end else begin
        bus.din_valid = 1'b0;
      end
    end
    tick();
    chk("b2b_cnt", bus.match_cnt, 2);
    chk("b2b_sticky", bus.sticky_match, 1);
    chk("b2b_mv_end", bus.match_valid, 0);

    // 2-bit counter: saturation, then clear coincident with a match.
    bus.din = VAL48;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk($sformatf("c2_mv_t%0d", t), c2_mv, (t >= 3 && t <= 7));
      chk($sformatf("c2_match_t%0d", t), c2_m, (t >= 3 && t <= 7));
      if (t >= 4) chk($sformatf("c2_cnt_t%0d", t), c2_cnt, (t - 3 > 3) ? 3 : t - 3);
      c2_dv = (t < 5);
    end
    chk("c2_sticky_sat", c2_st, 1);
    tick();
    c2_dv = 1'b1;
    tick();
    c2_dv = 1'b0;
    tick();
    tick();
    chk("c2_sixth_match", c2_m, 1);
    chk("c2_cnt_held", c2_cnt, 3);
    c2_clr = 1'b1;
    tick();
    c2_clr = 1'b0;
    chk("c2_clr_match_cnt", c2_cnt, 1);
    chk("c2_clr_match_sticky", c2_st, 1);
    tick();
    c2_clr = 1'b1;
    tick();
    c2_clr = 1'b0;
    chk("c2_clr_alone_cnt", c2_cnt, 0);
    chk("c2_clr_alone_sticky", c2_st, 0);

    // sclr with two matching words in flight.
    pulse_clear();
    chk("pre_sclr_cnt", bus.match_cnt, 0);
    tick();
    bus.din       = VAL48;
    bus.din_valid = 1'b1;
    tick();
    tick();
    bus.din_valid = 1'b0;
    sclr          = 1'b1;
    tick();
    sclr          = 1'b0;
    for (int t = 0; t < 6; t++) begin
      chk($sformatf("sclr_mv_t%0d", t), bus.match_valid, 0);
      chk($sformatf("sclr_cnt_t%0d", t), bus.match_cnt, 0);
      chk($sformatf("sclr_sticky_t%0d", t), bus.sticky_match, 0);
      tick();
    end

    // Width sweep against a reference compare and fixed latencies.
    for (int t = 0; t < SW_CYC; t++) begin
      tick();
      for (int g = 0; g < SW_N; g++) begin
        if (t >= SW_LAT[g]) begin
          ev = hv[g][t - SW_LAT[g]];
          em = hm[g][t - SW_LAT[g]];
        end else begin
          ev = 1'b0;
          em = 1'b0;
        end
        chk($sformatf("w%0d_mv_t%0d", SW_W[g], t), sw_mv[g], ev);
        chk($sformatf("w%0d_match_t%0d", SW_W[g], t), sw_m[g], em);
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 9) == 0) d = (SW_VAL & SW_CARE) | (rnd & ~SW_CARE);
        else d = rnd;
        dv = (t < 120) && ($urandom_range(0, 9) < 8);
        sw_din[g] = d;
        sw_dv[g]  = dv;
        hv[g][t]  = dv;
        hm[g][t]  = dv && ((((d ^ SW_VAL) & SW_CARE) & wmask(SW_W[g])) == '0);
        if (hm[g][t]) nmatch[g]++;
      end
    end
    for (int g = 0; g < SW_N; g++) begin
      chk($sformatf("w%0d_cnt", SW_W[g]), sw_cnt[g], 16'(nmatch[g]));
      chk($sformatf("w%0d_sticky", SW_W[g]), sw_st[g], nmatch[g] != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eq_const_pipe.md
EQ_CONST_PIPE -- requirements
Module: eq_const_pipe

Interface
REQ-001 The module SHALL have parameter TARGET_CHIP, default 2: device family selector passed to every LUT primitive.
REQ-002 The module SHALL have parameter WIDTH, default 48: compared word width, legal range 1..256.
REQ-003 The module SHALL have parameter VAL, default 48'h0123_4567_89AB: WIDTH-bit match constant.
REQ-004 The module SHALL have parameter CARE, default all ones: WIDTH-bit mask, 1 = bit compared, 0 = don't-care.
REQ-005 The module SHALL have parameter CNT_WIDTH, default 16: match counter width, legal range 1..32.
REQ-006 The module SHALL use one clock and a synchronous, active-high reset.
REQ-007 The module SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-008 The module SHALL have port sclr, input, width 1: synchronous active-high reset.
REQ-009 The module SHALL have port din, input, width WIDTH: word to compare.
REQ-010 The module SHALL have port din_valid, input, width 1: qualifies din this cycle.
REQ-011 The module SHALL have port clear_stats, input, width 1: synchronous clear of match_cnt and sticky_match.
REQ-012 The module SHALL have port match, output, width 1: compare result, meaningful when match_valid=1.
REQ-013 The module SHALL have port match_valid, output, width 1: din_valid delayed by LATENCY.
REQ-014 The module SHALL have port match_cnt, output, width CNT_WIDTH: saturating count of valid matches.
REQ-015 The module SHALL have port sticky_match, output, width 1: set by any valid match and held until cleared.

Function
REQ-016 The module SHALL split din into NCH = ceil(WIDTH/6) chunks of 6 bits, starting at bit 0, with the top chunk padded by don't-care bits.
REQ-017 Each chunk SHALL be compared against its slice of VAL under CARE in a single 6-input LUT, with the result registered (level 0).
REQ-018 Chunk results SHALL be AND-reduced in groups of up to 6 per LUT, with each tree level registered, until one bit remains.
REQ-019 LATENCY SHALL equal 1 plus the number of reduction levels (WIDTH=6 -> 1; WIDTH=48 -> 3; WIDTH=256 -> 4).
REQ-020 match and match_valid SHALL present the result for din sampled LATENCY cycles earlier; the pipeline SHALL accept a new word every cycle with no stall.
REQ-021 A valid cycle with din equal to VAL on every CARE bit SHALL yield match=1; any CARE-bit mismatch SHALL yield match=0.
REQ-022 CARE all zeros SHALL make every valid word match.
REQ-023 match SHALL be forced to 0 whenever match_valid=0.
REQ-024 match_cnt SHALL increment by 1 in the cycle after match_valid=1 and match=1, and SHALL saturate at 2^CNT_WIDTH-1 without wrapping.
REQ-025 sticky_match SHALL be set in the cycle after match_valid=1 and match=1.
REQ-026 When clear_stats=1 and a valid match occur in the same cycle, match_cnt SHALL become 1 and sticky_match SHALL become 1.
REQ-027 When clear_stats=1 occurs alone, match_cnt SHALL become 0 and sticky_match SHALL become 0 in the next cycle.
REQ-028 clear_stats SHALL NOT affect the compare pipeline.

Reset
REQ-029 During sclr=1, match_valid, match, match_cnt and sticky_match SHALL all be 0 in the next cycle, and every pipeline valid stage SHALL be cleared.
REQ-030 sclr asserted mid-stream SHALL discard all in-flight words; no match_valid SHALL appear for them after sclr deasserts.
REQ-031 Data and chunk registers SHALL NOT require reset, because the valid qualification covers them.
REQ-032 sclr SHALL take priority over clear_stats and over a match.

Structure
REQ-033 A shared package eq_const_pkg SHALL hold the functions for chunk count (ceil WIDTH/6), tree levels (ceil log6) and LATENCY.
REQ-034 A single sub-module eq_chunk_reg SHALL implement a 6-bit masked constant compare plus its output register, and SHALL be instantiated NCH times.
REQ-035 The LUT mask for each chunk SHALL be computed at elaboration time as the OR of 1<<k over every k agreeing with VAL on the CARE bits.

Verification
REQ-036 With WIDTH=48 and default VAL/CARE, din=48'h0123_4567_89AB with valid SHALL give match=1 and match_valid=1 exactly 3 cycles later, and match_cnt SHALL reach 1.
REQ-037 Back-to-back words VAL, VAL^1, VAL^(1<<47), VAL SHALL give the match sequence 1,0,0,1 in consecutive cycles, with match_cnt ending at 2.
REQ-038 With CARE=48'hFFFF_FFFF_FF00, din=48'h0123_4567_8900 SHALL give match=1, and din=48'h0123_4567_8800 SHALL give match=0.
REQ-039 With CNT_WIDTH=2 and 5 matching words, match_cnt SHALL hold at 3; clear_stats together with a sixth match SHALL give match_cnt=1 and sticky_match=1.
REQ-040 Two matching words in flight followed by sclr=1 for 1 cycle SHALL produce no match_valid, and match_cnt and sticky_match SHALL remain 0.
REQ-041 Sweeps of WIDTH over {1,6,7,36,37,256} with random din and 10% injected VAL SHALL match a reference model and its LATENCY formula.
